// File: rtl/gpac_adc_trigger_gen.sv
// Threshold self-trigger for the raw ADC sample stream (ADC_ENC domain).
// Fires one-cycle pulses on qualified crossings, with hysteresis re-arm and hold-off.
module gpac_adc_trigger_gen #(
  parameter int HOLDOFF_WIDTH = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     ADC_ENC,
  input  logic                     ADC_RST_N,
  input  logic [13:0]              ADC_IN,
  input  logic                     CONF_EN,
  input  logic                     CONF_POLARITY,
  input  logic [13:0]              CONF_THRESHOLD,
  input  logic [13:0]              CONF_HYST,
  input  logic [3:0]               CONF_MIN_WIDTH,
  input  logic [HOLDOFF_WIDTH-1:0] CONF_HOLDOFF,
  input  logic                     CNT_CLEAR,
  output logic                     ADC_TRIGGER,
  output logic                     ARMED,
  output logic [CNT_WIDTH-1:0]     TRIG_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REARM,
    S_ARMED,
    S_QUAL,
    S_HOLD
  } state_e;

  localparam logic [HOLDOFF_WIDTH-1:0] HOne =
    {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] COne =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [13:0]              adc_q;
  logic [3:0]               qcnt_q, qcnt_d;
  logic [HOLDOFF_WIDTH-1:0] hcnt_q, hcnt_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     trig_q, armed_q, armed_d;
  logic                     fire;
  logic                     qual, rearm;
  logic [14:0]              adc15, th15, hy15;
  logic [3:0]               w_eff;

  // 15-bit sums so threshold +/- hysteresis never wraps
  always_comb begin
    adc15 = {1'b0, adc_q};
    th15  = {1'b0, CONF_THRESHOLD};
    hy15  = {1'b0, CONF_HYST};
    if (CONF_POLARITY) begin
      qual  = adc15 <= th15;
      rearm = adc15 > (th15 + hy15);
    end else begin
      qual  = adc15 >= th15;
      rearm = (adc15 + hy15) < th15;
    end
    w_eff = (CONF_MIN_WIDTH == 4'd0) ? 4'd1 : CONF_MIN_WIDTH;
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    hcnt_d  = hcnt_q;
    fire    = 1'b0;
    if (!CONF_EN) begin
      state_d = S_IDLE;
      qcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_REARM;
        S_REARM: if (rearm) state_d = S_ARMED;
        S_ARMED: begin
          if (qual) begin
            qcnt_d = 4'd1;
            if (w_eff == 4'd1) fire = 1'b1;
            else state_d = S_QUAL;
          end
        end
        S_QUAL: begin
          if (qual) begin
            qcnt_d = qcnt_q + 4'd1;
            if ((qcnt_q + 4'd1) == w_eff) fire = 1'b1;
          end else begin
            qcnt_d  = '0;
            state_d = S_ARMED;
          end
        end
        S_HOLD: begin
          hcnt_d = hcnt_q - HOne;
          if (hcnt_q <= HOne) state_d = S_REARM;
        end
        default: state_d = S_IDLE;
      endcase
      if (fire) begin
        qcnt_d = '0;
        hcnt_d = CONF_HOLDOFF;
        state_d = (CONF_HOLDOFF == '0) ? S_REARM : S_HOLD;
      end
    end
  end

  // clear beats a coincident fire; count sticks at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLEAR) cnt_d = '0;
    else if (fire && (cnt_q != '1)) cnt_d = cnt_q + COne;
    armed_d = (state_d == S_ARMED) || (state_d == S_QUAL);
  end

  always_ff @(posedge ADC_ENC or negedge ADC_RST_N) begin
    if (!ADC_RST_N) begin
      state_q <= S_IDLE;
      adc_q   <= '0;
      qcnt_q  <= '0;
      hcnt_q  <= '0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adc_q   <= ADC_IN;
      qcnt_q  <= qcnt_d;
      hcnt_q  <= hcnt_d;
      cnt_q   <= cnt_d;
      trig_q  <= fire;
      armed_q <= armed_d;
    end
  end

  assign ADC_TRIGGER = trig_q;
  assign ARMED       = armed_q;
  assign TRIG_CNT    = cnt_q;

endmodule

// File: tb/tb_gpac_adc_trigger_gen.sv
// Directed and randomized bench for gpac_adc_trigger_gen.
// Expected values come from a sample-level model of the trigger rules.
module tb_gpac_adc_trigger_gen;

  localparam int HW = 16;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [13:0]   adc_in;
  logic          conf_en;
  logic          conf_pol;
  logic [13:0]   conf_th;
  logic [13:0]   conf_hyst;
  logic [3:0]    conf_w;
  logic [HW-1:0] conf_hold;
  logic          cnt_clr;
  logic          trig;
  logic          armed;
  logic [CW-1:0] trig_cnt;

  gpac_adc_trigger_gen #(
    .HOLDOFF_WIDTH(HW),
    .CNT_WIDTH(CW)
  ) dut (
    .ADC_ENC(clk),
    .ADC_RST_N(rst_n),
    .ADC_IN(adc_in),
    .CONF_EN(conf_en),
    .CONF_POLARITY(conf_pol),
    .CONF_THRESHOLD(conf_th),
    .CONF_HYST(conf_hyst),
    .CONF_MIN_WIDTH(conf_w),
    .CONF_HOLDOFF(conf_hold),
    .CNT_CLEAR(cnt_clr),
    .ADC_TRIGGER(trig),
    .ARMED(armed),
    .TRIG_CNT(trig_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fire = -1;

  // model: sample-level view of the trigger rules
  int m_adc;
  bit m_active;
  bit m_wait;
  int m_run;
  int m_dead;
  int m_cnt;
  bit m_trig;
  bit m_armed;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_adc = 0; m_active = 0; m_wait = 0; m_run = 0;
    m_dead = 0; m_cnt = 0; m_trig = 0; m_armed = 0;
  endtask

  task automatic model_edge();
    int  w;
    int  th;
    int  hy;
    bit  q;
    bit  ra;
    bit  fire;
    w  = (conf_w == 0) ? 1 : int'(conf_w);
    th = int'(conf_th);
    hy = int'(conf_hyst);
    if (conf_pol) begin
      q  = m_adc <= th;
      ra = m_adc > th + hy;
    end else begin
      q  = m_adc >= th;
      ra = m_adc + hy < th;
    end
    fire = 0;
    if (!conf_en) begin
      m_active = 0; m_wait = 0; m_run = 0; m_dead = 0;
    end else if (!m_active) begin
      m_active = 1; m_wait = 1;
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) m_wait = 1;
    end else if (m_wait) begin
      if (ra) m_wait = 0;
    end else if (q) begin
      m_run++;
      if (m_run == w) fire = 1;
    end else begin
      m_run = 0;
    end
    if (fire) begin
      m_run  = 0;
      m_dead = int'(conf_hold);
      m_wait = (conf_hold == 0);
    end
    if (cnt_clr) m_cnt = 0;
    else if (fire && m_cnt < CMAX) m_cnt++;
    m_trig  = fire;
    m_armed = m_active && !m_wait && (m_dead == 0);
    m_adc   = int'(adc_in);
  endtask

  task automatic step(input logic [13:0] a, input logic clr = 1'b0);
    adc_in  = a;
    cnt_clr = clr;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chk("trigger", 32'(trig), 32'(m_trig));
    chk("armed", 32'(armed), 32'(m_armed));
    chk("trig_cnt", 32'(trig_cnt), 32'(m_cnt));
    if (trig === 1'b1) begin
      if (last_fire >= 0)
        chk("holdoff_gap",
            32'((cyc - last_fire) >= 1 + int'(conf_hold)), 32'd1);
      last_fire = cyc;
    end
  endtask

  task automatic set_cfg(input bit pol, input int th, input int hy,
                         input int w, input int hold, input bit clr);
    conf_en   = 1'b0;
    conf_pol  = pol;
    conf_th   = 14'(th);
    conf_hyst = 14'(hy);
    conf_w    = 4'(w);
    conf_hold = HW'(hold);
    step(adc_in, clr);
    conf_en   = 1'b1;
    last_fire = -1;
  endtask

  initial begin
    int base;
    int v;
    rst_n = 1'b0;
    adc_in = '0; conf_en = 1'b0; conf_pol = 1'b0;
    conf_th = '0; conf_hyst = '0; conf_w = '0;
    conf_hold = '0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trigger", 32'(trig), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_cnt", 32'(trig_cnt), 32'd0);
    rst_n = 1'b1;

    // 1: simple rising crossing, two-edge latency
    set_cfg(0, 1000, 50, 1, 0, 1);
    step(900); step(900);
    step(1000);
    chk("t1_early", 32'(trig), 32'd0);
    step(1000);
    chk("t1_fire", 32'(trig), 32'd1);
    chk("t1_cnt", 32'(trig_cnt), 32'd1);
    step(1000);
    chk("t1_single", 32'(trig), 32'd0);

    // 2: enabled above threshold, re-arm needs a full hysteresis drop
    set_cfg(0, 1000, 50, 1, 0, 1);
    repeat (22) step(1200);
    chk("t2_no_trig", 32'(trig_cnt), 32'd0);
    step(940); step(1000); step(1000);
    chk("t2_fire", 32'(trig), 32'd1);
    repeat (3) step(960);
    repeat (3) step(1000);
    chk("t2_no_second", 32'(trig_cnt), 32'd1);

    // 3: minimum width 4
    set_cfg(0, 1000, 50, 4, 0, 1);
    repeat (3) step(900);
    repeat (3) step(1100);
    step(900);
    chk("t3_short_burst", 32'(trig_cnt), 32'd0);
    repeat (4) step(1100);
    chk("t3_not_yet", 32'(trig), 32'd0);
    step(1100);
    chk("t3_fire", 32'(trig), 32'd1);
    repeat (3) step(900);
    chk("t3_cnt", 32'(trig_cnt), 32'd1);

    // 4: falling with hold-off, square wave
    set_cfg(1, 500, 20, 1, 10, 1);
    repeat (10) begin
      repeat (3) step(600);
      repeat (3) step(400);
    end
    chk("t4_some_trig", 32'(trig_cnt > 0), 32'd1);

    // 6: disable during hold-off, re-enable above threshold
    set_cfg(0, 1000, 50, 1, 10, 1);
    step(900); step(900); step(1100); step(1100);
    chk("t6_fire", 32'(trig), 32'd1);
    step(1100);
    conf_en = 1'b0;
    repeat (2) step(1100);
    conf_en = 1'b1;
    repeat (12) step(1100);
    chk("t6_no_retrig", 32'(trig_cnt), 32'd1);
    step(900); step(900); step(1100); step(1100);
    chk("t6_new_fire", 32'(trig), 32'd1);

    // 5a: counter saturation
    set_cfg(0, 1000, 50, 1, 0, 0);
    repeat (CMAX + 40) begin
      step(900); step(1100);
    end
    chk("t5_saturate", 32'(trig_cnt), 32'(CMAX));

    // 5b: clear coincident with a fire
    set_cfg(0, 1000, 50, 1, 0, 0);
    step(900); step(900); step(1100);
    step(900, 1'b1);
    chk("t5_clr_fire", 32'(trig), 32'd1);
    chk("t5_clr_cnt", 32'(trig_cnt), 32'd0);

    // 5c: asynchronous reset mid-qualify
    set_cfg(0, 1000, 50, 4, 0, 0);
    step(900); step(900); step(1100); step(1100); step(1100);
    chk("t5_in_qual", 32'(armed), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_trig", 32'(trig), 32'd0);
    chk("t5_async_armed", 32'(armed), 32'd0);
    chk("t5_async_cnt", 32'(trig_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // randomized configurations and samples
    for (int blk = 0; blk < 24; blk++) begin
      base = int'($urandom_range(16383));
      set_cfg(1'($urandom_range(1)), base,
              ($urandom_range(7) == 0) ? int'($urandom_range(16383))
                                       : int'($urandom_range(300)),
              int'($urandom_range(5)), int'($urandom_range(8)),
              1'($urandom_range(1)));
      for (int i = 0; i < 150; i++) begin
        v = base + int'($urandom_range(800)) - 400;
        if (v < 0) v = 0;
        if (v > 16383) v = 16383;
        if ($urandom_range(59) == 0) conf_en = ~conf_en;
        step(14'(v), 1'($urandom_range(49) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/gpac_adc_trigger_gen.md
Name: gpac_adc_trigger_gen

Overview:
Self-trigger generator in the ADC_ENC domain. It watches the raw 14-bit ADC sample stream and produces a single-cycle ADC_TRIGGER pulse when the signal crosses a programmable threshold. The signal must stay past the threshold for a minimum width. Hysteresis re-arm and a hold-off window follow each trigger. ADC_TRIGGER feeds the external-trigger input of the ADC receiver core, which records a frame when CONF_EN_EX_TRIGGER is set. Configuration inputs are quasi-static and are synchronised to ADC_ENC by the instantiating wrapper.

Parameters:
HOLDOFF_WIDTH, 16, width of CONF_HOLDOFF and of the hold-off counter.
CNT_WIDTH, 16, width of TRIG_CNT.

Ports:
ADC_ENC  input  1  sample clock; the only clock.
ADC_RST_N  input  1  asynchronous, active-low reset.
ADC_IN  input  14  unsigned raw ADC sample, one per ADC_ENC cycle.
CONF_EN  input  1  level; 1 = trigger logic enabled.
CONF_POLARITY  input  1  0 = rising crossing, 1 = falling crossing.
CONF_THRESHOLD  input  14  crossing level.
CONF_HYST  input  14  re-arm hysteresis.
CONF_MIN_WIDTH  input  4  consecutive qualifying samples required; 0 is treated as 1.
CONF_HOLDOFF  input  HOLDOFF_WIDTH  dead cycles after a trigger.
CNT_CLEAR  input  1  single-cycle pulse; clears TRIG_CNT.
ADC_TRIGGER  output  1  registered one-cycle trigger pulse.
ARMED  output  1  registered; high while in state ARMED or QUALIFY.
TRIG_CNT  output  CNT_WIDTH  saturating count of issued triggers.

Behaviour:
- Reset (ADC_RST_N=0, asynchronous): state=IDLE, ADC_TRIGGER=0, ARMED=0, TRIG_CNT=0, internal counters 0, adc_q=0.
- Input stage: ADC_IN is registered into adc_q on every edge. All comparisons use adc_q, in 15-bit unsigned arithmetic with no wrap.
- Qualify and re-arm conditions:
  - POLARITY=0: qual = adc_q >= THRESHOLD; rearm = adc_q + HYST < THRESHOLD.
  - POLARITY=1: qual = adc_q <= THRESHOLD; rearm = adc_q > THRESHOLD + HYST.
  - If the re-arm level falls outside 0..16383, rearm never becomes true and the block stays in REARM.
- Effective width W = max(CONF_MIN_WIDTH, 1).
- State machine (registered, one transition per edge):
  - IDLE: if CONF_EN=1, go to REARM.
  - REARM: if rearm, go to ARMED. The block never triggers on a signal that is already past threshold at enable.
  - ARMED: if qual, set qcnt=1. If W=1, fire; else go to QUALIFY.
  - QUALIFY: if qual, qcnt++; fire when qcnt+1 == W. If not qual, set qcnt=0 and return to ARMED (not REARM).
  - Fire: ADC_TRIGGER=1 for exactly one cycle; TRIG_CNT++; go to HOLDOFF with hcnt=CONF_HOLDOFF. If CONF_HOLDOFF=0, go directly to REARM.
  - HOLDOFF: decrement hcnt each cycle; go to REARM when hcnt reaches 1. Exactly CONF_HOLDOFF cycles are spent in HOLDOFF.
- Latency: if samples S0..S(W-1) qualify, with S0 applied on ADC_IN before edge E0, ADC_TRIGGER is high in the cycle following edge E(W). For W=1 that is 2 edges after S0 is applied.
- CONF_EN=0 in any state: next edge goes to IDLE and clears qcnt and hcnt. ADC_TRIGGER stays 0 from that edge on. TRIG_CNT is held.
- Configuration changes mid-operation take effect on the next comparison. No state is restarted.
- TRIG_CNT saturates at all-ones. If CNT_CLEAR coincides with a fire, clear wins and TRIG_CNT=0.
- ARMED output is registered from the next state, so it is coincident with the state.

Test Plan:
1. Rising, TH=1000, HYST=50, W=1, HOLDOFF=0. Enable with ADC_IN=900, then ramp to 1000 -> one ADC_TRIGGER pulse 2 edges after the 1000 sample. TRIG_CNT=1.
2. Enable while ADC_IN=1200 (above TH), hold 20 cycles -> no trigger. Drop to 940, then 1000 -> trigger. Drop to 960 (not below 950), then rise to 1000 -> no second trigger.
3. W=4: pulse of 3 samples at 1100, then 900, then 4 samples at 1100 -> first burst does not trigger; exactly one trigger, high after the 4th qualifying sample edge.
4. Falling, TH=500, HYST=20, HOLDOFF=10: square wave 600/400 with period 6 -> triggers spaced ≥ 1+10 cycles apart. No trigger during the HOLDOFF window.
5. Edge cases:
   - TRIG_CNT preset near saturation via 65535 triggers -> stays 0xFFFF.
   - CNT_CLEAR coincident with a fire -> TRIG_CNT=0.
   - ADC_RST_N asserted mid-QUALIFY -> ADC_TRIGGER and ARMED go 0 immediately, without waiting for a clock edge.
6. Clear CONF_EN in HOLDOFF, then set it again with the signal past threshold -> state passes IDLE→REARM. No trigger until re-arm plus a new crossing.
